// File: rtl/slice_packer_pkg.sv
// Shared widths and FSM state for the slice packer.
package slice_packer_pkg;
   localparam int SLICE_W = 16;
   localparam int NSLICES = 16;
   localparam int FRAME_W = SLICE_W * NSLICES;
   localparam int IDX_W   = $clog2(NSLICES);

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;
endpackage

// File: rtl/slice_packer_slice_dec.sv
// Slot index plus write strobe to one-hot slice write enable.
module slice_dec #(
   parameter int N  = 16,
   parameter int IW = $clog2(N)
) (
   input  logic [IW-1:0] idx,
   input  logic          we,
   output logic [N-1:0]  en
);
   always_comb begin
      en = '0;
      if (we) en[idx] = 1'b1;
   end
endmodule

// File: rtl/slice_packer.sv
// Packs successive slices into a frame; releases it on a
// valid/ready handshake, then restarts from slice 0.
module slice_packer #(
   parameter int SLICE_W = slice_packer_pkg::SLICE_W,
   parameter int NSLICES = slice_packer_pkg::NSLICES
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [SLICE_W-1:0]         in_data,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [SLICE_W*NSLICES-1:0] result,
   output logic [4:0]                 count
);
   import slice_packer_pkg::*;

   localparam int         IW   = $clog2(NSLICES);
   localparam logic [4:0] LAST = 5'(NSLICES - 1);

   state_t             state;
   logic               accept;
   logic               clr;
   logic [NSLICES-1:0] wen;

   assign in_ready = (state == FILL) && !reset;
   assign accept   = in_valid && in_ready;
   assign clr      = (state == HOLD) && out_ready;

   slice_dec #(
      .N  (NSLICES),
      .IW (IW)
   ) u_dec (
      .idx (count[IW-1:0]),
      .we  (accept),
      .en  (wen)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= FILL;
         count     <= '0;
         out_valid <= 1'b0;
      end else begin
         unique case (state)
            FILL: begin
               if (accept) begin
                  count <= count + 5'd1;
                  if (count == LAST || flush) begin
                     state     <= HOLD;
                     out_valid <= 1'b1;
                  end
               end else if (flush && count != 5'd0) begin
                  state     <= HOLD;
                  out_valid <= 1'b1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= FILL;
                  out_valid <= 1'b0;
                  count     <= '0;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

   // Clearing on release keeps unwritten slices of the next frame zero.
   for (genvar k = 0; k < NSLICES; k++) begin : g_slot
      logic [SLICE_W-1:0] slot_q;

      always_ff @(posedge clk) begin
         if (reset || clr) slot_q <= '0;
         else if (wen[k]) slot_q <= in_data;
      end

      assign result[k*SLICE_W +: SLICE_W] = slot_q;
   end
endmodule

// File: tb/tb_slice_packer.sv
// Randomized scoreboard bench for slice_packer.
module tb_slice_packer;
   import slice_packer_pkg::*;

   typedef struct packed {
      logic [FRAME_W-1:0] data;
      logic [4:0]         cnt;
   } exp_t;

   logic               clk = 1'b0;
   logic               reset;
   logic               in_valid;
   logic               in_ready;
   logic [SLICE_W-1:0] in_data;
   logic               flush;
   logic               out_valid;
   logic               out_ready;
   logic [FRAME_W-1:0] result;
   logic [4:0]         count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   exp_t               expq[$];
   int                 pulse_cyc[$];
   logic [SLICE_W-1:0] cur[$];
   bit                 holding = 0;
   exp_t               held;

   slice_packer dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .count     (count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [FRAME_W-1:0] pack_cur();
      logic [FRAME_W-1:0] f = '0;
      foreach (cur[k]) f[k*SLICE_W +: SLICE_W] = cur[k];
      return f;
   endfunction

   task automatic chk(input string name, input logic [FRAME_W-1:0] act,
                      input logic [FRAME_W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, req);
      end
   endtask

   // One clock of stimulus; the model decides what the block must do.
   task automatic step(input bit rst, input bit iv, input logic [15:0] d,
                       input bit fl, input bit ordy);
      @(posedge clk);
      #1;
      reset = rst; in_valid = iv; in_data = d; flush = fl; out_ready = ordy;
      #1;
      chk("in_ready", FRAME_W'(in_ready), FRAME_W'(!holding && !rst));
      chk("out_valid", FRAME_W'(out_valid), FRAME_W'(holding));
      if (holding) begin
         chk("hold_result", result, held.data);
         chk("hold_count", FRAME_W'(count), FRAME_W'(held.cnt));
      end else begin
         chk("fill_result", result, pack_cur());
         chk("fill_count", FRAME_W'(count), FRAME_W'(cur.size()));
      end
      if (rst) begin
         if (holding) void'(expq.pop_back());
         holding = 0;
         cur.delete();
      end else if (holding) begin
         if (ordy) holding = 0;
      end else begin
         if (iv) cur.push_back(d);
         if (cur.size() == NSLICES || (fl && cur.size() > 0)) begin
            held.data = pack_cur();
            held.cnt  = 5'(cur.size());
            expq.push_back(held);
            holding = 1;
            cur.delete();
         end
      end
   endtask

   always @(negedge clk) begin
      if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         exp_t e;
         pulse_cyc.push_back(cyc);
         checks++;
         if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame at cycle %0d: got %h want none",
                     cyc, result);
         end else begin
            e = expq.pop_front();
            if (result !== e.data || count !== e.cnt) begin
               errors++;
               $display("FAIL frame at cycle %0d: got %h/%0d want %h/%0d",
                        cyc, result, count, e.data, e.cnt);
            end
         end
      end
   end

   initial begin
      int base;
      reset = 1; in_valid = 0; in_data = '0; flush = 0; out_ready = 0;
      repeat (2) @(posedge clk);
      step(0, 0, 0, 0, 0);

      for (int k = 0; k < 16; k++) step(0, 1, 16'(k), 0, 0);
      repeat (3) step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);

      step(0, 1, 16'hAAAA, 0, 0);
      step(0, 1, 16'hBBBB, 0, 0);
      step(0, 1, 16'hCCCC, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);

      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 1);
      for (int k = 0; k < 4; k++) step(0, 1, 16'($urandom), 0, 0);
      step(0, 1, 16'h5555, 1, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);

      for (int k = 0; k < 16; k++) step(0, 1, 16'($urandom), 0, 0);
      for (int k = 0; k < 10; k++) step(0, k[0], 16'($urandom), k[1], 0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);

      for (int k = 0; k < 7; k++) step(0, 1, 16'($urandom), 0, 1);
      step(1, 1, 16'hDEAD, 1, 1);
      for (int k = 0; k < 16; k++) step(0, 1, 16'(k + 100), 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      step(0, 1, 16'h7, 0, 1);
      step(1, 0, 0, 0, 0);

      base = pulse_cyc.size();
      for (int k = 0; k < 51; k++) step(0, 1, 16'($urandom), 0, 1);
      step(0, 0, 0, 0, 0);
      chk("stream_pulses", FRAME_W'(pulse_cyc.size() - base), FRAME_W'(3));
      if (pulse_cyc.size() - base == 3)
         for (int k = 1; k < 3; k++)
            chk("stream_gap", FRAME_W'(pulse_cyc[base+k] - pulse_cyc[base+k-1]),
                FRAME_W'(17));

      for (int k = 0; k < 2000; k++)
         step($urandom_range(99) == 0, $urandom_range(9) < 7, 16'($urandom),
              $urandom_range(9) == 0, $urandom_range(1) == 1);

      repeat (3) step(0, 0, 0, 0, 1);
      chk("queue_empty", FRAME_W'(expq.size()), FRAME_W'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
